// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory controller: access sizes, FSM states
// and the alignment / load-extension helpers.
package dmem_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    function automatic logic is_misaligned(input logic [2:0] offset, input logic [1:0] size);
        logic r;
        r = 1'b0;
        case (size)
            SIZE_H:  r = offset[0];
            SIZE_W:  r = |offset[1:0];
            SIZE_D:  r = |offset;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Lanes arrive already shifted down to bit 0; only the low 2^size bytes matter.
    function automatic logic [63:0] extend_load(input logic [63:0] lanes, input logic [1:0] size,
                                                input logic zero_ext);
        logic [63:0] r;
        r = lanes;
        case (size)
            SIZE_B:  r = zero_ext ? {56'd0, lanes[7:0]}  : {{56{lanes[7]}}, lanes[7:0]};
            SIZE_H:  r = zero_ext ? {48'd0, lanes[15:0]} : {{48{lanes[15]}}, lanes[15:0]};
            SIZE_W:  r = zero_ext ? {32'd0, lanes[31:0]} : {{32{lanes[31]}}, lanes[31:0]};
            default: r = lanes;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/data_memory_array.sv
// Word-organised storage with per-byte write enables and a registered read port.
// Contents start at INIT_VALUE and are never touched by reset.
module data_memory_array
    import dmem_pkg::*;
#(
    parameter int          DATA_W     = 64,
    parameter int          DEPTH      = 32,
    parameter logic [63:0] INIT_VALUE = 64'd5,
    localparam int         BYTES      = DATA_W / 8,
    localparam int         IDX_W      = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic [IDX_W-1:0]  idx,
    input  logic [BYTES-1:0]  wr_be,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH] = '{default: DATA_W'(INIT_VALUE)};
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        for (int b = 0; b < BYTES; b++) begin
            if (wr_be[b]) begin
                mem_q[idx][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
        end
        if (rd_en) begin
            rd_data_q <= mem_q[idx];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/data_memory_ctrl.sv
// Load/store front end for the data memory: valid/ready handshake, fixed read
// latency, byte-lane store enables and sign/zero-extended loads.
module data_memory_ctrl
    import dmem_pkg::*;
#(
    parameter int          DATA_W     = 64,
    parameter int          DEPTH      = 32,
    parameter int          ADDR_W     = 64,
    parameter int          LATENCY    = 1,
    parameter logic [63:0] INIT_VALUE = 64'd5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         size_q, size_d;
    logic               zext_q, zext_d;
    logic [OFF_W-1:0]   off_q, off_d;
    logic               err_q, err_d;
    logic               no_data_q, no_data_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q, rsp_err_d;

    logic               accept;
    logic [OFF_W-1:0]   req_off;
    logic [IDX_W-1:0]   req_idx;
    logic               req_err;
    logic [7:0]         size_mask;
    logic [BYTES-1:0]   lane_mask;
    logic [BYTES-1:0]   wr_be;
    logic [DATA_W-1:0]  wr_data;
    logic               rd_en;
    logic [DATA_W-1:0]  arr_rdata;
    logic [DATA_W-1:0]  lanes;
    logic               unused_addr;

    assign req_ready   = (state_q == IDLE);
    assign accept      = req_valid && req_ready;
    assign req_off     = req_addr[OFF_W-1:0];
    assign req_idx     = req_addr[OFF_W +: IDX_W];
    assign unused_addr = ^req_addr[ADDR_W-1:OFF_W+IDX_W];
    assign req_err     = is_misaligned(3'(req_off), req_size) || (DATA_W == 32 && req_size == SIZE_D);

    always_comb begin
        size_mask = 8'hFF;
        case (req_size)
            SIZE_B:  size_mask = 8'h01;
            SIZE_H:  size_mask = 8'h03;
            SIZE_W:  size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    end

    // Errored accesses neither write nor read; the response is still produced.
    assign lane_mask = BYTES'(16'(size_mask) << req_off);
    assign wr_be     = (accept && req_we && !req_err) ? lane_mask : '0;
    assign wr_data   = req_wdata << {req_off, 3'b000};
    assign rd_en     = accept && !req_we && !req_err;

    data_memory_array #(
        .DATA_W     (DATA_W),
        .DEPTH      (DEPTH),
        .INIT_VALUE (INIT_VALUE)
    ) u_array (
        .clk     (clk),
        .idx     (req_idx),
        .wr_be   (wr_be),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_data (arr_rdata)
    );

    assign lanes = arr_rdata >> {off_q, 3'b000};

    // RESP spends one cycle registering the response before raising rsp_valid,
    // which is what makes rsp_valid land LATENCY edges after the accept.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        size_d      = size_q;
        zext_d      = zext_q;
        off_d       = off_q;
        err_d       = err_q;
        no_data_d   = no_data_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    size_d    = req_size;
                    zext_d    = req_unsigned;
                    off_d     = req_off;
                    err_d     = req_err;
                    no_data_d = req_we || req_err;
                    if (LATENCY > 1) begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(LATENCY - 2);
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (!rsp_valid_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = no_data_q ? '0 : DATA_W'(extend_load(64'(lanes), size_q, zext_q));
                    rsp_err_d   = err_q;
                end else if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            size_q      <= SIZE_B;
            zext_q      <= 1'b0;
            off_q       <= '0;
            err_q       <= 1'b0;
            no_data_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            size_q      <= size_d;
            zext_q      <= zext_d;
            off_q       <= off_d;
            err_q       <= err_d;
            no_data_q   <= no_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Self-checking bench for data_memory_ctrl (64-bit words, 32 deep, latency 3):
// vector table through a response scoreboard plus backpressure and reset sequences.
module tb_data_memory_ctrl;
    import dmem_pkg::*;

    localparam int DATA_W = 64;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = 64;
    localparam int LAT    = 3;
    localparam int NV     = 19;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] want_rdata;
        logic        want_err;
    } vec_t;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
    } want_t;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    want_t sb[$];
    vec_t  vecs[NV];
    int    n_compared;
    int    n_mismatched;

    data_memory_ctrl #(
        .DATA_W     (DATA_W),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W),
        .LATENCY    (LAT),
        .INIT_VALUE (64'd5)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] want);
        n_compared++;
        if (actual !== want) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, want);
        end
    endtask

    // Drives one request, waits (bounded) for the accept edge and records the expected response.
    task automatic applyStimulus(input vec_t v);
        int waited;
        @(negedge clk);
        req_we       = v.we;
        req_size     = v.size;
        req_unsigned = v.uns;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        req_valid    = 1'b1;
        waited       = 0;
        while (req_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 50) begin
            checkOutput("accept_timeout", 64'd0, 64'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        sb.push_back('{v.want_rdata, v.want_err});
        #1;
        req_valid    = 1'b0;
        req_addr     = {$urandom, $urandom};
        req_wdata    = {$urandom, $urandom};
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_we       = 1'($urandom);
    endtask

    // Called #1 after the accept edge; counts edges until rsp_valid and checks against the scoreboard.
    task automatic collectResponse(input string tag, input bit complete);
        int    k;
        want_t w;
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
            if (rsp_valid !== 1'b1) checkOutput({tag, "_busy_ready"}, 64'(req_ready), 64'd0);
        end while (rsp_valid !== 1'b1 && k < 20);
        checkOutput({tag, "_latency"}, 64'(k), 64'(LAT));
        if (sb.size() == 0) begin
            checkOutput({tag, "_sb_empty"}, 64'd0, 64'd1);
            return;
        end
        w = sb.pop_front();
        checkOutput({tag, "_rdata"}, rsp_rdata, w.rdata);
        checkOutput({tag, "_err"}, 64'(rsp_err), 64'(w.err));
        if (complete) begin
            @(posedge clk);
            #1;
            checkOutput({tag, "_valid_drop"}, 64'(rsp_valid), 64'd0);
            checkOutput({tag, "_ready_back"}, 64'(req_ready), 64'd1);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t v;
        n_compared   = 0;
        n_mismatched = 0;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = SIZE_B;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        rsp_ready    = 1'b1;

        vecs[0]  = '{1'b0, SIZE_D, 1'b0, 64'h10,  64'h0,                   64'd5,                   1'b0};
        vecs[1]  = '{1'b1, SIZE_D, 1'b0, 64'h08,  64'h0123_4567_89AB_CDEF, 64'h0,                   1'b0};
        vecs[2]  = '{1'b0, SIZE_D, 1'b0, 64'h08,  64'h0,                   64'h0123_4567_89AB_CDEF, 1'b0};
        vecs[3]  = '{1'b1, SIZE_B, 1'b0, 64'h0B,  64'h1234_5678_9ABC_DE80, 64'h0,                   1'b0};
        vecs[4]  = '{1'b0, SIZE_B, 1'b0, 64'h0B,  64'h0,                   64'hFFFF_FFFF_FFFF_FF80, 1'b0};
        vecs[5]  = '{1'b0, SIZE_B, 1'b1, 64'h0B,  64'h0,                   64'h80,                  1'b0};
        vecs[6]  = '{1'b0, SIZE_D, 1'b0, 64'h08,  64'h0,                   64'h0123_4567_80AB_CDEF, 1'b0};
        vecs[7]  = '{1'b0, SIZE_W, 1'b0, 64'h06,  64'h0,                   64'h0,                   1'b1};
        vecs[8]  = '{1'b1, SIZE_H, 1'b0, 64'h01,  64'hBEEF,                64'h0,                   1'b1};
        vecs[9]  = '{1'b0, SIZE_D, 1'b0, 64'h00,  64'h0,                   64'd5,                   1'b0};
        vecs[10] = '{1'b0, SIZE_H, 1'b0, 64'h0A,  64'h0,                   64'hFFFF_FFFF_FFFF_80AB, 1'b0};
        vecs[11] = '{1'b0, SIZE_W, 1'b1, 64'h0C,  64'h0,                   64'h0123_4567,           1'b0};
        vecs[12] = '{1'b0, SIZE_W, 1'b0, 64'h08,  64'h0,                   64'hFFFF_FFFF_80AB_CDEF, 1'b0};
        vecs[13] = '{1'b1, SIZE_W, 1'b0, 64'h14,  64'h5555_5555_DEAD_BEEF, 64'h0,                   1'b0};
        vecs[14] = '{1'b0, SIZE_D, 1'b0, 64'h10,  64'h0,                   64'hDEAD_BEEF_0000_0005, 1'b0};
        vecs[15] = '{1'b0, SIZE_H, 1'b1, 64'h16,  64'h0,                   64'hDEAD,                1'b0};
        vecs[16] = '{1'b1, SIZE_D, 1'b0, 64'h100, 64'hAA,                  64'h0,                   1'b0};
        vecs[17] = '{1'b0, SIZE_D, 1'b0, 64'h000, 64'h0,                   64'hAA,                  1'b0};
        vecs[18] = '{1'b0, SIZE_D, 1'b0, 64'h0C,  64'h0,                   64'h0,                   1'b1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("reset_req_ready", 64'(req_ready), 64'd1);
        checkOutput("reset_rsp_rdata", rsp_rdata, 64'd0);
        checkOutput("reset_rsp_err", 64'(rsp_err), 64'd0);

        for (int i = 0; i < NV; i++) begin
            applyStimulus(vecs[i]);
            collectResponse($sformatf("vec%0d", i), 1'b1);
        end

        // Backpressure: response held while a new request waits for req_ready.
        rsp_ready = 1'b0;
        v = '{1'b0, SIZE_D, 1'b0, 64'h08, 64'h0, 64'h0123_4567_80AB_CDEF, 1'b0};
        applyStimulus(v);
        collectResponse("bp", 1'b0);
        req_we       = 1'b1;
        req_size     = SIZE_D;
        req_unsigned = 1'b0;
        req_addr     = 64'h18;
        req_wdata    = 64'h1111;
        req_valid    = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            checkOutput("bp_valid", 64'(rsp_valid), 64'd1);
            checkOutput("bp_hold", rsp_rdata, 64'h0123_4567_80AB_CDEF);
            checkOutput("bp_req_ready", 64'(req_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_release_valid", 64'(rsp_valid), 64'd0);
        checkOutput("bp_release_ready", 64'(req_ready), 64'd1);
        @(posedge clk);
        sb.push_back('{64'h0, 1'b0});
        #1;
        req_valid = 1'b0;
        collectResponse("held_store", 1'b1);
        v = '{1'b0, SIZE_D, 1'b0, 64'h18, 64'h0, 64'h1111, 1'b0};
        applyStimulus(v);
        collectResponse("held_load", 1'b1);

        // Reset during WAIT of a store: response dropped, store still committed.
        v = '{1'b1, SIZE_D, 1'b0, 64'h28, 64'h7777, 64'h0, 1'b0};
        applyStimulus(v);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        sb.delete();
        checkOutput("rstwait_valid", 64'(rsp_valid), 64'd0);
        checkOutput("rstwait_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (LAT + 2) @(posedge clk);
        #1;
        checkOutput("rstwait_no_rsp", 64'(rsp_valid), 64'd0);
        checkOutput("rstwait_idle", 64'(req_ready), 64'd1);
        v = '{1'b0, SIZE_D, 1'b0, 64'h28, 64'h0, 64'h7777, 1'b0};
        applyStimulus(v);
        collectResponse("rstwait_commit", 1'b1);

        // Reset while a response is being held: outputs clear immediately.
        rsp_ready = 1'b0;
        v = '{1'b0, SIZE_D, 1'b0, 64'h08, 64'h0, 64'h0123_4567_80AB_CDEF, 1'b0};
        applyStimulus(v);
        collectResponse("rstresp", 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        sb.delete();
        checkOutput("rstresp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("rstresp_rdata", rsp_rdata, 64'd0);
        checkOutput("rstresp_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        #1;
        checkOutput("rstresp_idle", 64'(req_ready), 64'd1);
        v = '{1'b0, SIZE_B, 1'b1, 64'h29, 64'h0, 64'h77, 1'b0};
        applyStimulus(v);
        collectResponse("post_reset", 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
